bus_dma_master: RTL and testbench

Byte-copy engine that acts as an initiator on the 8-bit MMIO bus, the same bus used by the timer, UART and RAM responders. It accepts a single copy command (source address, destination address, length, increment modes), performs one read and one write bus access per byte, and signals completion. Bus ownership is shared with the CPU through a request/grant pair. The arbiter is outside this block.

---
 rtl/bus_pkg.sv | 18 +
 rtl/bus_dma_master_if.sv | 24 ++
 rtl/bus_dma_master.sv | 130 +++++++++++++
 tb/tb_bus_dma_master.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared definitions for the 8-bit MMIO bus and the DMA copy engine.
//   BUS_AW / BUS_DW : bus address / data widths
//   LEN_W           : width of the remaining-byte counter (holds 1..256)
//   dma_state_t     : copy engine FSM encoding
package bus_pkg;

  localparam int unsigned BUS_AW = 8;
  localparam int unsigned BUS_DW = 8;
  localparam int unsigned LEN_W  = 9;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    READ   = 2'd1,
    WRITE  = 2'd2,
    FINISH = 2'd3
  } dma_state_t;

endpackage

// File: rtl/bus_dma_master_if.sv
// MMIO bus connection between an initiator and its arbiter/responders.
//   master : drives bus_req, bus_cs, bus_we, bus_addr, bus_wdata; samples bus_gnt, bus_rdata
//   slave  : the opposite view (arbiter + responder side)
interface bus_dma_master_if;

  logic                          bus_req;
  logic                          bus_gnt;
  logic                          bus_cs;
  logic                          bus_we;
  logic [bus_pkg::BUS_AW-1:0]    bus_addr;
  logic [bus_pkg::BUS_DW-1:0]    bus_wdata;
  logic [bus_pkg::BUS_DW-1:0]    bus_rdata;

  modport master (
    output bus_req, bus_cs, bus_we, bus_addr, bus_wdata,
    input  bus_gnt, bus_rdata
  );

  modport slave (
    input  bus_req, bus_cs, bus_we, bus_addr, bus_wdata,
    output bus_gnt, bus_rdata
  );

endinterface

// File: rtl/bus_dma_master.sv
// Byte-copy DMA initiator: one read + one write bus access per byte.
//   clk, rst        : clock, asynchronous active-high reset
//   cmd_*           : copy command (src, dst, len with 0 = 256, increment modes)
//   cmd_ready       : engine idle, command accepted on cmd_valid && cmd_ready
//   abort           : cancel a transfer in progress
//   done / aborted  : one-cycle completion pulses
//   bus             : MMIO initiator port (request/grant, chip select, address/data)
module bus_dma_master
  import bus_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [BUS_AW-1:0] cmd_src,
  input  logic [BUS_AW-1:0] cmd_dst,
  input  logic [BUS_AW-1:0] cmd_len,
  input  logic              cmd_src_inc,
  input  logic              cmd_dst_inc,
  input  logic              abort,
  output logic              done,
  output logic              aborted,
  bus_dma_master_if.master  bus
);

  dma_state_t        state_q, state_d;
  logic [BUS_AW-1:0] src_q, src_d;
  logic [BUS_AW-1:0] dst_q, dst_d;
  logic              src_inc_q, src_inc_d;
  logic              dst_inc_q, dst_inc_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic [BUS_DW-1:0] data_q, data_d;
  logic              aborted_q, aborted_d;

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      src_q     <= '0;
      dst_q     <= '0;
      src_inc_q <= 1'b0;
      dst_inc_q <= 1'b0;
      rem_q     <= '0;
      data_q    <= '0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      src_inc_q <= src_inc_d;
      dst_inc_q <= dst_inc_d;
      rem_q     <= rem_d;
      data_q    <= data_d;
      aborted_q <= aborted_d;
    end
  end

  // Next-state and counter update; abort wins over a granted access
  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    dst_d     = dst_q;
    src_inc_d = src_inc_q;
    dst_inc_d = dst_inc_q;
    rem_d     = rem_q;
    data_d    = data_q;
    aborted_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          src_d     = cmd_src;
          dst_d     = cmd_dst;
          src_inc_d = cmd_src_inc;
          dst_inc_d = cmd_dst_inc;
          rem_d     = (cmd_len == '0) ? LEN_W'(256) : LEN_W'(cmd_len);
          state_d   = READ;
        end
      end
      READ: begin
        if (abort) begin
          state_d   = IDLE;
          aborted_d = 1'b1;
        end else if (bus.bus_gnt) begin
          data_d  = bus.bus_rdata;
          state_d = WRITE;
        end
      end
      WRITE: begin
        if (abort) begin
          state_d   = IDLE;
          aborted_d = 1'b1;
        end else if (bus.bus_gnt) begin
          src_d   = src_q + {{(BUS_AW-1){1'b0}}, src_inc_q};
          dst_d   = dst_q + {{(BUS_AW-1){1'b0}}, dst_inc_q};
          rem_d   = rem_q - LEN_W'(1);
          state_d = (rem_q == LEN_W'(1)) ? FINISH : READ;
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Status decode and gated bus drive; only bus_cs (and what it gates) follows bus_gnt
  always_comb begin
    cmd_ready     = (state_q == IDLE);
    done          = (state_q == FINISH);
    aborted       = aborted_q;
    bus.bus_req   = (state_q == READ) || (state_q == WRITE);
    bus.bus_cs    = bus.bus_req && bus.bus_gnt;
    bus.bus_we    = 1'b0;
    bus.bus_addr  = '0;
    bus.bus_wdata = '0;
    if (bus.bus_cs) begin
      if (state_q == WRITE) begin
        bus.bus_we    = 1'b1;
        bus.bus_addr  = dst_q;
        bus.bus_wdata = data_q;
      end else begin
        bus.bus_addr  = src_q;
      end
    end
  end

endmodule

// File: tb/tb_bus_dma_master.sv
// Self-checking bench for bus_dma_master: RAM/timer responder model plus a
// byte-level copy reference that predicts every cycle's bus outputs.
module tb_bus_dma_master;
  import bus_pkg::*;

  localparam int unsigned CYC_LIMIT = 3000;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_src;
  logic [7:0] cmd_dst;
  logic [7:0] cmd_len;
  logic       cmd_src_inc;
  logic       cmd_dst_inc;
  logic       abort;
  logic       done;
  logic       aborted;

  logic [7:0] ram       [256];
  logic [7:0] fill_data [256];
  logic [7:0] ref_mem   [256];
  logic       fill;
  logic       timer_en;

  int errors = 0;
  int checks = 0;

  bus_dma_master_if bif ();

  bus_dma_master dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_src     (cmd_src),
    .cmd_dst     (cmd_dst),
    .cmd_len     (cmd_len),
    .cmd_src_inc (cmd_src_inc),
    .cmd_dst_inc (cmd_dst_inc),
    .abort       (abort),
    .done        (done),
    .aborted     (aborted),
    .bus         (bif)
  );

  always #5 clk = ~clk;

  // RAM responder; a write to 0x92 also sets the timer enable from bit 0
  always_ff @(posedge clk) begin
    if (fill) begin
      ram      <= fill_data;
      timer_en <= 1'b0;
    end else if (bif.bus_cs && bif.bus_we) begin
      ram[bif.bus_addr] <= bif.bus_wdata;
      if (bif.bus_addr == 8'h92) timer_en <= bif.bus_wdata[0];
    end
  end

  assign bif.bus_rdata = ram[bif.bus_addr];

  function automatic logic [21:0] mkvec(input logic req, input logic cs, input logic we,
                                        input logic [7:0] a, input logic [7:0] wd,
                                        input logic dn, input logic ab, input logic rdy);
    return {req, cs, we, a, wd, dn, ab, rdy};
  endfunction

  function automatic logic [21:0] obs();
    return {bif.bus_req, bif.bus_cs, bif.bus_we, bif.bus_addr, bif.bus_wdata,
            done, aborted, cmd_ready};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Loads fresh random contents into the RAM; starts and ends at posedge+1
  task automatic do_fill();
    for (int i = 0; i < 256; i++) fill_data[i] = 8'($urandom);
    fill = 1'b1;
    @(posedge clk); #1;
    fill = 1'b0;
  endtask

  // One copy command. stall_acc: access index that sees a 3-cycle grant gap.
  // abort_at / rst_at: access index at which abort / rst is raised (-1 = never).
  task automatic run_copy(input logic [7:0] s, input logic [7:0] d, input logic [7:0] l,
                          input logic si, input logic di, input int stall_pct,
                          input int stall_acc, input int abort_at, input int rst_at);
    int n, acc, cyc, wrs, wexp, stall_left, mode, k, mism;
    logic g, ab, rs, odd;
    logic [7:0] ra, wa, rd;
    logic [21:0] exp;

    cmd_src     = s;
    cmd_dst     = d;
    cmd_len     = l;
    cmd_src_inc = si;
    cmd_dst_inc = di;
    cmd_valid   = 1'b1;
    abort       = 1'b0;
    bif.bus_gnt = 1'($urandom_range(1));
    @(negedge clk);
    check("idle_before_cmd", 32'(obs()), 32'(mkvec(0, 0, 0, 8'h00, 8'h00, 0, 0, 1)));
    ref_mem = ram;
    @(posedge clk); #1;

    n = (l == 8'd0) ? 256 : int'(l);
    acc = 0; cyc = 0; wrs = 0; wexp = 0; stall_left = 3; mode = -1; rd = 8'h00;
    while (mode < 0 && cyc < int'(CYC_LIMIT)) begin
      g = ($urandom_range(99) >= 32'(stall_pct));
      if (acc == stall_acc && stall_left > 0) begin
        g = 1'b0;
        stall_left--;
      end
      ab = (acc == abort_at);
      rs = (acc == rst_at);
      bif.bus_gnt = g;
      abort       = ab;
      cmd_valid   = (ab || rs) ? 1'b0 : 1'($urandom_range(1));
      cmd_src     = 8'($urandom);
      cmd_len     = 8'($urandom);
      if (rs) rst = 1'b1;
      @(negedge clk);
      odd = acc[0];
      k   = acc / 2;
      ra  = 8'(int'(s) + (si ? k : 0));
      wa  = 8'(int'(d) + (di ? k : 0));
      if (rs) exp = mkvec(0, 0, 0, 8'h00, 8'h00, 0, 0, 1);
      else    exp = mkvec(1, g, g && odd, g ? (odd ? wa : ra) : 8'h00,
                          (g && odd) ? rd : 8'h00, 0, 0, 0);
      check("bus_cycle", 32'(obs()), 32'(exp));
      if (bif.bus_cs && bif.bus_we) wrs++;
      if (!rs && g) begin
        if (!odd) rd = ref_mem[ra];
        else begin
          ref_mem[wa] = rd;
          wexp++;
        end
        acc++;
      end
      if (!g) ;
      cyc++;
      if (rs)                mode = 2;
      else if (ab)           mode = 1;
      else if (acc == 2 * n) mode = 0;
      @(posedge clk); #1;
    end
    check("cycle_budget", 32'(cyc < int'(CYC_LIMIT)), 32'd1);

    cmd_valid = 1'b0;
    if (mode == 0) begin
      abort = 1'($urandom_range(1));
      @(negedge clk);
      check("done_pulse", 32'(obs()), 32'(mkvec(0, 0, 0, 8'h00, 8'h00, 1, 0, 0)));
      @(posedge clk); #1;
      abort = 1'b0;
      @(negedge clk);
      check("ready_back", 32'(obs()), 32'(mkvec(0, 0, 0, 8'h00, 8'h00, 0, 0, 1)));
    end else if (mode == 1) begin
      abort = 1'b0;
      bif.bus_gnt = 1'b1;
      @(negedge clk);
      check("aborted_pulse", 32'(obs()), 32'(mkvec(0, 0, 0, 8'h00, 8'h00, 0, 1, 1)));
      @(posedge clk); #1;
      @(negedge clk);
      check("after_abort", 32'(obs()), 32'(mkvec(0, 0, 0, 8'h00, 8'h00, 0, 0, 1)));
    end else begin
      rst = 1'b0;
      bif.bus_gnt = 1'b1;
      for (int i = 0; i < 2; i++) begin
        @(negedge clk);
        check("after_reset", 32'(obs()), 32'(mkvec(0, 0, 0, 8'h00, 8'h00, 0, 0, 1)));
        @(posedge clk); #1;
      end
    end
    @(posedge clk); #1;

    check("write_count", 32'(wrs), 32'(wexp));
    mism = 0;
    for (int i = 0; i < 256; i++) if (ram[i] !== ref_mem[i]) mism++;
    check("ram_contents", 32'(mism), 32'd0);
  endtask

  initial begin
    int nb;
    logic [7:0] rs_, rd_, rl_;
    rst = 1'b1; fill = 1'b0; cmd_valid = 1'b0; cmd_src = '0; cmd_dst = '0; cmd_len = '0;
    cmd_src_inc = 1'b0; cmd_dst_inc = 1'b0; abort = 1'b0; bif.bus_gnt = 1'b1;

    // Reset values while held and after release
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("reset_held", 32'(obs()), 32'(mkvec(0, 0, 0, 8'h00, 8'h00, 0, 0, 1)));
    end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("reset_released", 32'(obs()), 32'(mkvec(0, 0, 0, 8'h00, 8'h00, 0, 0, 1)));
      @(posedge clk); #1;
    end

    // Basic copy, full grant
    do_fill();
    run_copy(8'h10, 8'h20, 8'd3, 1'b1, 1'b1, 0, -1, -1, -1);
    check("basic_dst", {8'h00, ram[8'h20], ram[8'h21], ram[8'h22]},
          {8'h00, fill_data[8'h10], fill_data[8'h11], fill_data[8'h12]});

    // Three-cycle grant gap in the second read
    do_fill();
    run_copy(8'h10, 8'h20, 8'd3, 1'b1, 1'b1, 0, 2, -1, -1);

    // Source wraps past 0xFF, fixed destination on the timer register
    do_fill();
    run_copy(8'hFE, 8'h92, 8'd4, 1'b1, 1'b0, 0, -1, -1, -1);
    check("timer_enable", 32'(timer_en), 32'(fill_data[8'h01][0]));

    // Length 0 means 256 bytes
    do_fill();
    run_copy(8'($urandom), 8'($urandom), 8'd0, 1'b1, 1'b1, 0, -1, -1, -1);

    // Abort in the third read of a 5-byte copy
    do_fill();
    run_copy(8'h40, 8'h60, 8'd5, 1'b1, 1'b1, 0, -1, 4, -1);

    // Reset raised during the second write
    do_fill();
    run_copy(8'h40, 8'h60, 8'd5, 1'b1, 1'b1, 0, -1, -1, 3);

    // Random commands with random grant stalls
    for (int t = 0; t < 8; t++) begin
      do_fill();
      rs_ = 8'($urandom);
      rd_ = 8'($urandom);
      rl_ = 8'($urandom_range(1, 24));
      nb  = int'(rl_);
      run_copy(rs_, rd_, rl_, 1'($urandom_range(1)), 1'($urandom_range(1)), 30, -1,
               (t == 5) ? int'($urandom_range(0, 2 * nb - 1)) : -1, -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
